hls4ml_mul_acc_pipe: RTL and testbench

HLS4ML_MUL_ACC_PIPE -- requirements
Module: hls4ml_mul_acc_pipe

---
 rtl/hls4ml_mul_pkg.sv | 22 ++
 rtl/hls4ml_mul_delay_line.sv | 39 +++
 rtl/hls4ml_mul_acc_pipe.sv | 131 +++++++++++++
 tb/tb_hls4ml_mul_acc_pipe.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hls4ml_mul_pkg.sv
// hls4ml_mul_pkg: default widths and parameter legality check
// shared by the hls4ml multiply-accumulate pipeline.
package hls4ml_mul_pkg;

   localparam int DEF_A_WIDTH   = 13;
   localparam int DEF_B_WIDTH   = 8;
   localparam int DEF_A_SIGNED  = 0;
   localparam int DEF_B_SIGNED  = 1;
   localparam int DEF_ACC_WIDTH = 32;
   localparam int DEF_P_WIDTH   = 21;
   localparam int DEF_NUM_STAGE = 3;

   function automatic bit params_ok(
      int aw, int bw, int accw, int pw, int ns
   );
      return (aw > 0) && (bw > 0) && (pw > 0)
         && (accw >= aw + bw + 1)
         && (pw <= accw)
         && (ns >= 2);
   endfunction

endpackage

// File: rtl/hls4ml_mul_delay_line.sv
// hls4ml_mul_delay_line: DEPTH-register shift pipe with clock enable.
// Ports: clk, reset (sync, high), ce, d -> q delayed DEPTH ce-cycles.
module hls4ml_mul_delay_line
   import hls4ml_mul_pkg::*;
#(
   parameter int WIDTH = 1,
   parameter int DEPTH = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             ce,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   generate
      if (DEPTH == 0) begin : g_wire
         logic unused_ctl;
         assign unused_ctl = &{1'b0, clk, reset, ce};
         assign q = d;
      end else begin : g_pipe
         logic [WIDTH-1:0] regs [DEPTH];

         always_ff @(posedge clk) begin
            if (reset) begin
               for (int i = 0; i < DEPTH; i++)
                  regs[i] <= '0;
            end else if (ce) begin
               regs[0] <= d;
               for (int i = 1; i < DEPTH; i++)
                  regs[i] <= regs[i-1];
            end
         end

         assign q = regs[DEPTH-1];
      end
   endgenerate

endmodule

// File: rtl/hls4ml_mul_acc_pipe.sv
// hls4ml_mul_acc_pipe: pipelined multiply-accumulate, NUM_STAGE registers
// from input capture to p. Ports: clk, reset (sync, high), ce (stall),
// in_valid/a/b/acc_en in; out_valid/p/sat_flag out.
// Macro HLS4ML_MUL_SAT_EN: clamp p to P_WIDTH signed range and raise sat_flag.
module hls4ml_mul_acc_pipe
   import hls4ml_mul_pkg::*;
#(
   parameter int A_WIDTH   = DEF_A_WIDTH,
   parameter int B_WIDTH   = DEF_B_WIDTH,
   parameter int A_SIGNED  = DEF_A_SIGNED,
   parameter int B_SIGNED  = DEF_B_SIGNED,
   parameter int ACC_WIDTH = DEF_ACC_WIDTH,
   parameter int P_WIDTH   = DEF_P_WIDTH,
   parameter int NUM_STAGE = DEF_NUM_STAGE
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      ce,
   input  logic                      in_valid,
   input  logic [A_WIDTH-1:0]        a,
   input  logic [B_WIDTH-1:0]        b,
   input  logic                      acc_en,
   output logic                      out_valid,
   output logic signed [P_WIDTH-1:0] p,
   output logic                      sat_flag
);

   localparam int PROD_W = A_WIDTH + B_WIDTH + 1;
   localparam int DL_W   = PROD_W + 2;
   localparam int DL_D   = NUM_STAGE - 2;

   generate
      if (!params_ok(A_WIDTH, B_WIDTH, ACC_WIDTH, P_WIDTH, NUM_STAGE))
      begin : g_bad_params
         $error("hls4ml_mul_acc_pipe: illegal parameters");
      end
   endgenerate

   // stage 1: input capture
   logic               s1_valid;
   logic               s1_acc_en;
   logic [A_WIDTH-1:0] s1_a;
   logic [B_WIDTH-1:0] s1_b;

   always_ff @(posedge clk) begin
      if (reset) begin
         s1_valid  <= 1'b0;
         s1_acc_en <= 1'b0;
         s1_a      <= '0;
         s1_b      <= '0;
      end else if (ce) begin
         s1_valid  <= in_valid;
         s1_acc_en <= acc_en;
         s1_a      <= a;
         s1_b      <= b;
      end
   end

   // operands widened to the product width so the product is exact
   logic                     a_fill;
   logic                     b_fill;
   logic signed [PROD_W-1:0] a_ext;
   logic signed [PROD_W-1:0] b_ext;
   logic signed [PROD_W-1:0] prod;

   assign a_fill = (A_SIGNED != 0) && s1_a[A_WIDTH-1];
   assign b_fill = (B_SIGNED != 0) && s1_b[B_WIDTH-1];
   assign a_ext  = {{(B_WIDTH+1){a_fill}}, s1_a};
   assign b_ext  = {{(A_WIDTH+1){b_fill}}, s1_b};
   assign prod   = a_ext * b_ext;

   // first delay register is the product stage
   logic [DL_W-1:0]   dl_q;
   logic              f_valid;
   logic              f_acc_en;
   logic [PROD_W-1:0] f_prod;

   hls4ml_mul_delay_line #(
      .WIDTH (DL_W),
      .DEPTH (DL_D)
   ) u_delay (
      .clk   (clk),
      .reset (reset),
      .ce    (ce),
      .d     ({s1_valid, s1_acc_en, prod}),
      .q     (dl_q)
   );

   assign {f_valid, f_acc_en, f_prod} = dl_q;

   // final stage: accumulator
   logic signed [ACC_WIDTH-1:0] acc;
   logic signed [ACC_WIDTH-1:0] prod_ext;

   assign prod_ext = ACC_WIDTH'($signed(f_prod));

   always_ff @(posedge clk) begin
      if (reset) begin
         acc       <= '0;
         out_valid <= 1'b0;
      end else if (ce) begin
         out_valid <= f_valid;
         if (f_valid)
            acc <= f_acc_en ? acc + prod_ext : prod_ext;
      end
   end

   // p follows acc, so it holds whenever acc holds
`ifdef HLS4ML_MUL_SAT_EN
   localparam int HI_W = ACC_WIDTH - P_WIDTH + 1;

   logic [HI_W-1:0] hi;
   logic            ovf;

   // in range only when all bits from the p sign bit upward agree
   assign hi  = acc[ACC_WIDTH-1:P_WIDTH-1];
   assign ovf = !((&hi) || !(|hi));

   always_comb begin
      sat_flag = ovf;
      p        = acc[P_WIDTH-1:0];
      if (ovf)
         p = acc[ACC_WIDTH-1] ? {1'b1, {(P_WIDTH-1){1'b0}}}
                              : {1'b0, {(P_WIDTH-1){1'b1}}};
   end
`else
   assign p        = acc[P_WIDTH-1:0];
   assign sat_flag = 1'b0;
`endif

endmodule

// File: tb/tb_hls4ml_mul_acc_pipe.sv
// tb_hls4ml_mul_acc_pipe: directed and random checks of the MAC pipe
// against a queue-based latency/accumulate model.
module tb_hls4ml_mul_acc_pipe;

   localparam int NS = 3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic               reset = 1'b1;
   logic               ce = 1'b1;
   logic               in_valid = 1'b0;
   logic [12:0]        a = '0;
   logic [7:0]         b = '0;
   logic               acc_en = 1'b0;
   logic               out_valid;
   logic signed [20:0] p;
   logic               sat_flag;

   logic               in_valid2 = 1'b0;
   logic [12:0]        a2 = '0;
   logic [7:0]         b2 = '0;
   logic               out_valid2;
   logic signed [20:0] p2;
   logic               sat2;

   hls4ml_mul_acc_pipe dut (
      .clk       (clk),
      .reset     (reset),
      .ce        (ce),
      .in_valid  (in_valid),
      .a         (a),
      .b         (b),
      .acc_en    (acc_en),
      .out_valid (out_valid),
      .p         (p),
      .sat_flag  (sat_flag)
   );

   hls4ml_mul_acc_pipe #(
      .NUM_STAGE (5),
      .A_SIGNED  (1)
   ) dut5 (
      .clk       (clk),
      .reset     (reset),
      .ce        (1'b1),
      .in_valid  (in_valid2),
      .a         (a2),
      .b         (b2),
      .acc_en    (1'b0),
      .out_valid (out_valid2),
      .p         (p2),
      .sat_flag  (sat2)
   );

   int checks = 0;
   int errors = 0;

   typedef struct {
      bit     v;
      bit     en;
      longint prod;
   } slot_t;

   slot_t pq[$];
   int    acc_m = 0;
   bit    ov_m = 1'b0;

   function automatic longint prod_of(logic [12:0] av, logic [7:0] bv);
      return longint'(av) * longint'($signed(bv));
   endfunction

   function automatic longint p_of(int acc);
      longint v;
      v = longint'(acc);
`ifdef HLS4ML_MUL_SAT_EN
      if (v > 1048575) v = 1048575;
      if (v < -1048576) v = -1048576;
`else
      v = v & 64'h1FFFFF;
      if (v >= 1048576) v = v - 2097152;
`endif
      return v;
   endfunction

   function automatic longint sat_of(int acc);
`ifdef HLS4ML_MUL_SAT_EN
      return (acc > 1048575 || acc < -1048576) ? 1 : 0;
`else
      return (acc == acc) ? 0 : 1;
`endif
   endfunction

   task automatic chk(string tag, logic signed [63:0] obs,
                      logic signed [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick(bit r, bit c, bit v, logic [12:0] av,
                       logic [7:0] bv, bit en);
      slot_t s;
      reset    = r;
      ce       = c;
      in_valid = v;
      a        = av;
      b        = bv;
      acc_en   = en;
      @(posedge clk);
      if (r) begin
         pq.delete();
         acc_m = 0;
         ov_m  = 1'b0;
      end else if (c) begin
         pq.push_back('{v, en, prod_of(av, bv)});
         if (pq.size() == NS) begin
            s    = pq.pop_front();
            ov_m = s.v;
            if (s.v)
               acc_m = s.en ? acc_m + int'(s.prod) : int'(s.prod);
         end else begin
            ov_m = 1'b0;
         end
      end
      #1;
      chk("out_valid", out_valid, ov_m);
      chk("p", p, p_of(acc_m));
      chk("sat_flag", sat_flag, sat_of(acc_m));
   endtask

   task automatic idle();
      tick(0, 1, 0, '0, '0, 0);
   endtask

   initial begin
      // reset
      tick(1, 1, 0, '0, '0, 0);
      tick(1, 0, 1, 13'd5, 8'd5, 1);
      chk("rst_p", p, 0);
      chk("rst_ov", out_valid, 0);

      // single full-scale load
      tick(0, 1, 1, 13'd8191, 8'h80, 0);
      idle();
      chk("single_early_ov", out_valid, 0);
      idle();
      chk("single_p", p, -1048448);
      chk("single_ov", out_valid, 1);
      idle();
      chk("single_ov_drop", out_valid, 0);

      // back-to-back accumulate
      tick(0, 1, 1, 13'd100, 8'd5, 0);
      tick(0, 1, 1, 13'd200, 8'hFD, 1);
      tick(0, 1, 1, 13'd10, 8'd10, 1);
      chk("b2b_p0", p, 500);
      idle();
      chk("b2b_p1", p, -100);
      idle();
      chk("b2b_p2", p, 0);
      chk("b2b_ov", out_valid, 1);

      // overflow / saturation
      tick(0, 1, 1, 13'd8191, 8'd127, 0);
      tick(0, 1, 1, 13'd8191, 8'd127, 1);
      idle();
      chk("ovf_first", p, 1040257);
      idle();
`ifdef HLS4ML_MUL_SAT_EN
      chk("ovf_p", p, 1048575);
      chk("ovf_sat", sat_flag, 1);
`else
      chk("ovf_p", p, -16638);
      chk("ovf_sat", sat_flag, 0);
`endif

      // stall with two samples in flight
      idle();
      idle();
      tick(0, 1, 1, 13'd7, 8'd9, 0);
      tick(0, 1, 1, 13'd2, 8'hFF, 1);
      tick(0, 0, 1, 13'd55, 8'd55, 1);
      chk("stall_ov0", out_valid, 0);
      chk("stall_hold", p, p_of(2080514));
      tick(0, 0, 1, 13'd66, 8'd66, 0);
      chk("stall_ov1", out_valid, 0);
      chk("stall_hold2", p, p_of(2080514));
      idle();
      chk("stall_r0", p, 63);
      chk("stall_r0_ov", out_valid, 1);
      idle();
      chk("stall_r1", p, 61);
      idle();
      chk("stall_end_ov", out_valid, 0);

      // reset with samples in flight
      tick(0, 1, 1, 13'd50, 8'd2, 0);
      tick(0, 1, 1, 13'd60, 8'd3, 1);
      tick(1, 1, 0, '0, '0, 0);
      chk("flush_p", p, 0);
      chk("flush_ov", out_valid, 0);
      tick(0, 1, 1, 13'd3, 8'd4, 1);
      chk("flush_ov1", out_valid, 0);
      idle();
      chk("flush_ov2", out_valid, 0);
      idle();
      chk("post_rst_p", p, 12);
      chk("post_rst_ov", out_valid, 1);

      // random traffic
      for (int i = 0; i < 400; i++) begin
         tick($urandom_range(0, 99) == 0,
              $urandom_range(0, 9) != 0,
              $urandom_range(0, 2) != 0,
              13'($urandom), 8'($urandom),
              $urandom_range(0, 3) != 0);
      end

      // five-stage signed instance
      idle();
      in_valid2 = 1'b1;
      a2        = 13'h1FFB;
      b2        = 8'hF9;
      idle();
      in_valid2 = 1'b0;
      a2        = '0;
      b2        = '0;
      idle();
      idle();
      idle();
      chk("ns5_early_ov", out_valid2, 0);
      idle();
      chk("ns5_p", p2, 35);
      chk("ns5_ov", out_valid2, 1);
      chk("ns5_sat", sat2, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
